// File: rtl/logs_map_engine.sv
// logs_map_engine
//   Iterates the logistic map x' = r*x*(1-x) in unsigned fixed point and
//   presents one new iterate every ITER_LEN clocks. One serial shift-add
//   multiplier is used twice per iteration: first p = x*(1-x), then q = y*r.
//
// Parameters
//   FRAC      fractional bits of x (0.FRAC) and r (2.FRAC)
//   ITER_LEN  clocks per map iteration, must be >= 2*FRAC+4
//   INIT_X    x after reset, also the reseed value
//
// Ports
//   clk         clock
//   reset       synchronous reset, active high
//   r           map parameter, unsigned 2.FRAC, latched at pace count 0
//   x           current iterate, unsigned 0.FRAC, registered
//   next_ready  one-cycle pulse in the cycle x takes a new value
//   busy        high while the multiplier is running (MUL1/MUL2)
//
// Build option
//   LOGS_MAP_RESEED_EN  when defined, a zero result is replaced by INIT_X so
//                       the map escapes the absorbing zero that truncation
//                       creates; when undefined, zero is kept.
module logs_map_engine #(
  parameter int FRAC     = 8,
  parameter int ITER_LEN = 100,
  parameter int INIT_X   = 1 << (FRAC - 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FRAC+1:0] r,
  output logic [FRAC-1:0] x,
  output logic            next_ready,
  output logic            busy
);

  localparam int PW = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;
  localparam int CW = $clog2(FRAC + 2) + 1;
  localparam int AW = 2 * FRAC + 2;

  localparam logic [PW-1:0]   PACE_LAST = PW'(ITER_LEN - 1);
  localparam logic [CW-1:0]   LAST1     = CW'(FRAC);
  localparam logic [CW-1:0]   LAST2     = CW'(FRAC + 1);
  localparam logic [FRAC-1:0] INIT_V    = FRAC'(INIT_X);

  generate
    if (ITER_LEN < 2 * FRAC + 4) begin : g_iter_len_check
      $error("logs_map_engine: ITER_LEN must be at least 2*FRAC+4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   pace;
  logic [FRAC+1:0] r_l;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [FRAC+1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [FRAC-1:0] x_next;

  logic [FRAC:0]   b_init;
  logic [AW-1:0]   acc_sum;
  logic [FRAC+1:0] z;
  logic [FRAC-1:0] z_fixed;

  // 1 - x as an unsigned 1.FRAC value; x = 0 gives exactly 2^FRAC.
  assign b_init  = {1'b1, {FRAC{1'b0}}} - {1'b0, x};
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign z       = acc_sum[2*FRAC+1:FRAC];

  // Saturate results at or above 1.0, then deal with the zero result.
  always_comb begin
    z_fixed = z[FRAC-1:0];
    if (|z[FRAC+1:FRAC]) begin
      z_fixed = {FRAC{1'b1}};
    end else if (z[FRAC-1:0] == '0) begin
`ifdef LOGS_MAP_RESEED_EN
      z_fixed = INIT_V;
`else
      z_fixed = '0;
`endif
    end
  end

  // The latch cycle also performs shift-add step 0 of the first product, so
  // both products fit in 2*FRAC+2 cycles and HOLD is reached before the
  // commit edge even at the minimum ITER_LEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pace       <= '0;
      r_l        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      x_next     <= '0;
      x          <= INIT_V;
      next_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      next_ready <= 1'b0;
      pace       <= (pace == PACE_LAST) ? '0 : pace + PW'(1);
      case (state)
        IDLE: begin
          if (pace == '0) begin
            r_l    <= r;
            acc    <= b_init[0] ? AW'(x) : '0;
            mcand  <= AW'(x) << 1;
            mplier <= {2'b00, b_init[FRAC:1]};
            cnt    <= CW'(1);
            busy   <= 1'b1;
            state  <= MUL1;
          end
        end
        MUL1: begin
          if (cnt == LAST1) begin
            acc    <= '0;
            mcand  <= AW'(acc_sum[2*FRAC-1:FRAC]);
            mplier <= r_l;
            cnt    <= '0;
            state  <= MUL2;
          end else begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        MUL2: begin
          if (cnt == LAST2) begin
            x_next <= z_fixed;
            busy   <= 1'b0;
            state  <= HOLD;
          end else begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (pace == PACE_LAST) begin
            x          <= x_next;
            next_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
